// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared board geometry and scanner state encoding
//
// Purpose: constants shared by the datapath, line detector, row clear
//          logic and board scanner, plus the scanner FSM state type.
// Ports:   none (package).
package tetris_pkg;

  localparam int BOARD_ROWS = 8;
  localparam int BOARD_COLS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } scan_state_e;

endpackage

// File: rtl/board_snapshot.sv
// rtl/board_snapshot.sv - one-deep pending board slot for the scanner
//
// Purpose: holds one board that arrived while a scan was in progress.
// Ports:
//   clka, restart_n   clock, asynchronous active-low reset
//   board_in          board to store
//   wr                store board_in into the slot
//   rd                consume the slot contents
//   full              slot holds a board
//   data              stored board
//   overrun           sticky, set when a stored board is overwritten
module board_snapshot #(
  parameter int W = 32
) (
  input  logic         clka,
  input  logic         restart_n,
  input  logic [W-1:0] board_in,
  input  logic         wr,
  input  logic         rd,
  output logic         full,
  output logic [W-1:0] data,
  output logic         overrun
);

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      full    <= 1'b0;
      data    <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr) begin
        // A simultaneous read takes the old board; the newer one remains.
        data <= board_in;
        full <= 1'b1;
        if (full && !rd) overrun <= 1'b1;
      end else if (rd) begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/board_scanner.sv
// rtl/board_scanner.sv - streams completed boards out row by row
//
// Purpose: snapshots each board from the datapath, streams its rows over a
//          valid/ready handshake and reports the all-ones row count.
// Ports:
//   clka, restart_n   clock, asynchronous active-low reset
//   board_in          board image, row r at [r*COLS +: COLS], row 0 on top
//   board_valid       one-cycle strobe qualifying board_in
//   row_ready         sink accepts the current row
//   row_valid         row_data/row_idx valid
//   row_data, row_idx current row cells and index
//   frame_done        one-cycle pulse after the last row is accepted
//   full_rows         all-ones row count of the last completed frame
//   busy              scan in progress
//   overrun           sticky, a pending board was overwritten
module board_scanner
  import tetris_pkg::*;
#(
  parameter int ROWS = BOARD_ROWS,
  parameter int COLS = BOARD_COLS
) (
  input  logic                      clka,
  input  logic                      restart_n,
  input  logic [ROWS*COLS-1:0]      board_in,
  input  logic                      board_valid,
  input  logic                      row_ready,
  output logic                      row_valid,
  output logic [COLS-1:0]           row_data,
  output logic [$clog2(ROWS)-1:0]   row_idx,
  output logic                      frame_done,
  output logic [$clog2(ROWS+1)-1:0] full_rows,
  output logic                      busy,
  output logic                      overrun
);

  localparam int W  = ROWS * COLS;
  localparam int IW = $clog2(ROWS);
  localparam int CW = $clog2(ROWS + 1);
  localparam logic [IW-1:0] LAST_ROW = IW'(ROWS - 1);

  scan_state_e state, state_nxt;

  logic [W-1:0]  frame;
  logic [CW-1:0] run_cnt;
  logic [CW-1:0] final_cnt;
  logic          xfer;
  logic          last_row;
  logic          load_frame;
  logic          load_pending;
  logic          snap_wr;
  logic          snap_rd;
  logic          displaced;
  logic          done_overrun;
  logic          pend_full;
  logic          pend_overrun;
  logic [W-1:0]  pend_data;

  // Outputs are decodes of registered state only.
  assign row_valid  = (state == SEND);
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);
  assign row_data   = frame[row_idx*COLS +: COLS];
  assign overrun    = pend_overrun | done_overrun;

  assign xfer      = row_valid && row_ready;
  assign last_row  = (row_idx == LAST_ROW);
  assign final_cnt = run_cnt + CW'(&row_data);

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    load_frame   = 1'b0;
    load_pending = 1'b0;
    snap_wr      = 1'b0;
    snap_rd      = 1'b0;
    displaced    = 1'b0;
    case (state)
      IDLE: begin
        if (board_valid) begin
          load_frame = 1'b1;
          state_nxt  = SEND;
        end
      end
      SEND: begin
        snap_wr = board_valid;
        if (xfer && last_row) state_nxt = DONE;
      end
      DONE: begin
        // The slot is always drained here: either scanned next or
        // displaced by a board arriving in this very cycle.
        snap_rd = pend_full;
        if (board_valid) begin
          load_frame = 1'b1;
          displaced  = pend_full;
          state_nxt  = SEND;
        end else if (pend_full) begin
          load_frame   = 1'b1;
          load_pending = 1'b1;
          state_nxt    = SEND;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      frame        <= '0;
      row_idx      <= '0;
      run_cnt      <= '0;
      full_rows    <= '0;
      done_overrun <= 1'b0;
    end else begin
      if (load_frame) begin
        frame   <= load_pending ? pend_data : board_in;
        row_idx <= '0;
        run_cnt <= '0;
      end else if (xfer) begin
        run_cnt <= final_cnt;
        if (last_row) begin
          // Published on entry to DONE so it lines up with frame_done.
          full_rows <= final_cnt;
          row_idx   <= '0;
        end else begin
          row_idx <= row_idx + 1'b1;
        end
      end
      if (displaced) done_overrun <= 1'b1;
    end
  end

  board_snapshot #(.W(W)) u_snapshot (
    .clka      (clka),
    .restart_n (restart_n),
    .board_in  (board_in),
    .wr        (snap_wr),
    .rd        (snap_rd),
    .full      (pend_full),
    .data      (pend_data),
    .overrun   (pend_overrun)
  );

endmodule

// File: tb/tb_board_scanner.sv
// tb/tb_board_scanner.sv - self-checking bench for board_scanner
module tb_board_scanner;

  logic        clka = 1'b0;
  logic        restart_n;
  logic [31:0] board_in;
  logic        board_valid;
  logic        row_ready;
  logic        row_valid;
  logic [3:0]  row_data;
  logic [2:0]  row_idx;
  logic        frame_done;
  logic [3:0]  full_rows;
  logic        busy;
  logic        overrun;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int done_cnt = 0;
  int last_done_cyc = -1;
  int row0_cyc = -1;
  logic prev_valid = 1'b0;

  logic [6:0] exp_rows[$];
  logic [3:0] exp_full[$];

  board_scanner dut (
    .clka        (clka),
    .restart_n   (restart_n),
    .board_in    (board_in),
    .board_valid (board_valid),
    .row_ready   (row_ready),
    .row_valid   (row_valid),
    .row_data    (row_data),
    .row_idx     (row_idx),
    .frame_done  (frame_done),
    .full_rows   (full_rows),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clka = ~clka;

  always @(posedge clka) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_rows(input logic [31:0] b, input int nrows);
    for (int r = 0; r < nrows; r++) exp_rows.push_back({3'(r), b[r*4 +: 4]});
  endtask

  task automatic push_board(input logic [31:0] b);
    int ones;
    ones = 0;
    push_rows(b, 8);
    for (int r = 0; r < 8; r++) if (b[r*4 +: 4] == 4'hF) ones++;
    exp_full.push_back(4'(ones));
  endtask

  // Scoreboard monitor: sampled on the falling edge.
  always @(negedge clka) begin
    logic [6:0] e;
    if (restart_n) begin
      if (row_valid && row_ready) begin
        if (exp_rows.size() == 0) begin
          check("row_unexpected", 32'(exp_rows.size()), 32'd1);
        end else begin
          e = exp_rows.pop_front();
          check("row_idx", 32'(row_idx), 32'(e[6:4]));
          check("row_data", 32'(row_data), 32'(e[3:0]));
        end
      end
      if (frame_done) begin
        done_cnt++;
        last_done_cyc = cyc;
        check("done_busy", 32'(busy), 32'd1);
        check("done_row_valid", 32'(row_valid), 32'd0);
        if (exp_full.size() == 0) check("done_unexpected", 32'(exp_full.size()), 32'd1);
        else check("full_rows", 32'(full_rows), 32'(exp_full.pop_front()));
      end
      if (row_valid && row_idx == 3'd0 && !prev_valid) row0_cyc = cyc;
      prev_valid = row_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic strobe(input logic [31:0] b);
    board_in    = b;
    board_valid = 1'b1;
    @(posedge clka); #1;
    board_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < budget) begin
      @(posedge clka); #1;
      n++;
    end
    if (done_cnt == start) check("done_timeout", 32'(done_cnt), 32'(start + 1));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_row_valid"}, 32'(row_valid), 32'd0);
    check({tag, "_row_data"}, 32'(row_data), 32'd0);
    check({tag, "_row_idx"}, 32'(row_idx), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_full_rows"}, 32'(full_rows), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  task automatic do_reset();
    restart_n = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clka);
    #1;
    restart_n = 1'b1;
  endtask

  initial begin
    int k;
    int d;
    int saved;
    restart_n   = 1'b0;
    board_in    = '0;
    board_valid = 1'b0;
    row_ready   = 1'b1;
    repeat (2) @(posedge clka);
    #1;
    do_reset();
    @(posedge clka); #1;

    // Single frame and timing.
    k = cyc;
    push_board(32'hF000_000F);
    strobe(32'hF000_000F);
    @(negedge clka);
    check("s1_busy_n1", 32'(busy), 32'd1);
    check("s1_row0_valid", 32'(row_valid), 32'd1);
    wait_done(40);
    check("s1_row0_cyc", 32'(row0_cyc), 32'(k + 1));
    check("s1_done_cyc", 32'(last_done_cyc), 32'(k + 9));
    @(negedge clka);
    check("s1_idle_busy", 32'(busy), 32'd0);
    check("s1_full_hold", 32'(full_rows), 32'd2);
    @(posedge clka); #1;

    // Backpressure on row 4.
    push_board(32'h8765_4F21);
    strobe(32'h8765_4F21);
    repeat (4) @(posedge clka);
    #1;
    row_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clka);
      check("bp_valid", 32'(row_valid), 32'd1);
      check("bp_idx", 32'(row_idx), 32'd4);
      check("bp_data", 32'(row_data), 32'h5);
      @(posedge clka); #1;
    end
    row_ready = 1'b1;
    wait_done(40);
    @(posedge clka); #1;

    // Pending and overrun: B overwritten by C.
    push_board(32'hFFFF_FFFF);
    push_board(32'h0F0F_0F0F);
    strobe(32'hFFFF_FFFF);
    strobe(32'h1111_1111);
    strobe(32'h0F0F_0F0F);
    @(negedge clka);
    check("s3_overrun", 32'(overrun), 32'd1);
    wait_done(40);
    d = last_done_cyc;
    wait_done(40);
    check("s3_c_row0_cyc", 32'(row0_cyc), 32'(d + 1));
    check("s3_q_empty", 32'(exp_rows.size()), 32'd0);

    do_reset();
    @(posedge clka); #1;

    // Board strobed in the DONE cycle with the slot empty.
    k = cyc;
    push_board(32'h0000_F000);
    push_board(32'hF0F0_F0F0);
    strobe(32'h0000_F000);
    repeat (8) @(posedge clka);
    #1;
    strobe(32'hF0F0_F0F0);
    check("s4_done_cyc", 32'(last_done_cyc), 32'(k + 9));
    wait_done(40);
    check("s4_e_row0_cyc", 32'(row0_cyc), 32'(k + 10));
    check("s4_overrun", 32'(overrun), 32'd0);
    @(posedge clka); #1;

    // Reset mid-scan at row 3, with a board waiting in the slot.
    push_rows(32'h7654_3210, 3);
    strobe(32'h7654_3210);
    strobe(32'hFFFF_FFFF);
    repeat (2) @(posedge clka);
    #1;
    check("s5_pre_idx", 32'(row_idx), 32'd3);
    saved = done_cnt;
    do_reset();
    repeat (4) @(posedge clka);
    #1;
    check("s5_no_done", 32'(done_cnt), 32'(saved));
    check("s5_pending_gone", 32'(busy), 32'd0);
    check("s5_q_drained", 32'(exp_rows.size()), 32'd0);
    k = cyc;
    push_board(32'h0000_000F);
    strobe(32'h0000_000F);
    wait_done(40);
    check("s5_row0_cyc", 32'(row0_cyc), 32'(k + 1));

    repeat (3) @(posedge clka);
    #1;
    check("end_rows_empty", 32'(exp_rows.size()), 32'd0);
    check("end_full_empty", 32'(exp_full.size()), 32'd0);
    check("end_frames", 32'(done_cnt), 32'd7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
